if_stage: RTL and testbench

Instruction-fetch stage of the 5-stage pipeline, directly upstream of the decode stage. Holds the program counter, issues one instruction-memory request at a time over a request/grant, response-valid handshake, and owns the IF/ID pipeline register that decode reads. It honours the decode stage's hazard stall and branch redirect. Responses that arrive during a stall are buffered, and in-flight fetches on a mispredicted path are dropped.

---
 rtl/if_stage.sv | 144 ++++++++++++++
 tb/tb_if_stage.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC, single-outstanding imem handshake,
// one-entry stall buffer and the IF/ID pipeline register.
module if_stage #(
   parameter int          N        = 32,
   parameter logic [N-1:0] RESET_PC = '0
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         hazard_detected_in,
   input  logic         br_taken,
   input  logic [N-1:0] br_target,
   output logic         imem_req,
   output logic [N-1:0] imem_addr,
   input  logic         imem_gnt,
   input  logic         imem_rvalid,
   input  logic [N-1:0] imem_rdata,
   output logic [N-1:0] instruction,
   output logic [N-1:0] pc_out,
   output logic         valid_out
);

   typedef enum logic [1:0] {
      S_FETCH,
      S_WAIT,
      S_DROP
   } state_e;

   localparam logic [N-1:0] INC = N'(4);

   state_e       state_q, state_d;
   logic [N-1:0] pc_q, pc_d;
   logic [N-1:0] req_pc_q, req_pc_d;
   logic         buf_full_q, buf_full_d;
   logic [N-1:0] buf_instr_q, buf_instr_d;
   logic [N-1:0] buf_pc_q, buf_pc_d;
   logic [N-1:0] instr_q, instr_d;
   logic [N-1:0] pc_out_q, pc_out_d;
   logic         valid_q, valid_d;

   logic         gnt_ok;
   logic         rsp_live;

   // Request only from FETCH with an empty buffer and no stall.
   always_comb begin
      imem_req = !rst && (state_q == S_FETCH) && !buf_full_q
                 && !hazard_detected_in;
      gnt_ok   = imem_req && imem_gnt;
      rsp_live = (state_q == S_WAIT) && imem_rvalid;
   end

   assign imem_addr   = pc_q;
   assign instruction = instr_q;
   assign pc_out      = pc_out_q;
   assign valid_out   = valid_q;

   // Next-state: redirect first, then fetch FSM and IF/ID update.
   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      req_pc_d    = req_pc_q;
      buf_full_d  = buf_full_q;
      buf_instr_d = buf_instr_q;
      buf_pc_d    = buf_pc_q;
      instr_d     = instr_q;
      pc_out_d    = pc_out_q;
      valid_d     = valid_q;

      if (br_taken) begin
         pc_d       = br_target;
         instr_d    = '0;
         valid_d    = 1'b0;
         buf_full_d = 1'b0;
         // A response landing in the redirect cycle is already consumed,
         // so only a still-pending fetch needs a DROP state.
         unique case (state_q)
            S_WAIT:  state_d = imem_rvalid ? S_FETCH : S_DROP;
            S_DROP:  state_d = imem_rvalid ? S_FETCH : S_DROP;
            default: state_d = gnt_ok ? S_DROP : S_FETCH;
         endcase
      end else begin
         unique case (state_q)
            S_FETCH: begin
               if (gnt_ok) begin
                  req_pc_d = pc_q;
                  pc_d     = pc_q + INC;
                  state_d  = S_WAIT;
               end
            end
            S_WAIT: begin
               if (imem_rvalid) state_d = S_FETCH;
            end
            S_DROP: begin
               if (imem_rvalid) state_d = S_FETCH;
            end
            default: state_d = S_FETCH;
         endcase

         if (hazard_detected_in) begin
            if (rsp_live) begin
               buf_full_d  = 1'b1;
               buf_instr_d = imem_rdata;
               buf_pc_d    = req_pc_q + INC;
            end
         end else if (buf_full_q) begin
            instr_d    = buf_instr_q;
            pc_out_d   = buf_pc_q;
            valid_d    = 1'b1;
            buf_full_d = 1'b0;
         end else if (rsp_live) begin
            instr_d  = imem_rdata;
            pc_out_d = req_pc_q + INC;
            valid_d  = 1'b1;
         end else begin
            valid_d = 1'b0;
         end
      end
   end

   // State and pipeline registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_FETCH;
         pc_q        <= RESET_PC;
         req_pc_q    <= '0;
         buf_full_q  <= 1'b0;
         buf_instr_q <= '0;
         buf_pc_q    <= '0;
         instr_q     <= '0;
         pc_out_q    <= '0;
         valid_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         req_pc_q    <= req_pc_d;
         buf_full_q  <= buf_full_d;
         buf_instr_q <= buf_instr_d;
         buf_pc_q    <= buf_pc_d;
         instr_q     <= instr_d;
         pc_out_q    <= pc_out_d;
         valid_q     <= valid_d;
      end
   end

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed cycle table for the fetch scenarios,
// then random traffic against a queue-based transaction model.
module tb_if_stage;

   localparam logic [31:0] RST_PC = 32'h0;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        hazard = 1'b0;
   logic        br = 1'b0;
   logic [31:0] tgt = '0;
   logic        gnt = 1'b0;
   logic        rvalid = 1'b0;
   logic [31:0] rdata = '0;
   logic        req;
   logic [31:0] addr;
   logic [31:0] ins;
   logic [31:0] pco;
   logic        vout;

   int vectors = 0;
   int errors  = 0;

   always #5 clk = ~clk;

   if_stage #(.N(32), .RESET_PC(RST_PC)) dut (
      .clk(clk),
      .rst(rst),
      .hazard_detected_in(hazard),
      .br_taken(br),
      .br_target(tgt),
      .imem_req(req),
      .imem_addr(addr),
      .imem_gnt(gnt),
      .imem_rvalid(rvalid),
      .imem_rdata(rdata),
      .instruction(ins),
      .pc_out(pco),
      .valid_out(vout)
   );

   typedef struct {
      logic        rst, haz, br;
      logic [31:0] tgt;
      logic        gnt, rv;
      logic [31:0] rd;
      logic        e_req;
      logic [31:0] e_addr;
      logic        e_v;
      logic [31:0] e_ins, e_pco;
   } vec_t;

   vec_t tbl[32];

   function automatic vec_t mk(
      logic r, logic h, logic b, logic [31:0] t, logic g, logic v,
      logic [31:0] d, logic eq, logic [31:0] ea, logic ev,
      logic [31:0] ei, logic [31:0] ep);
      vec_t x;
      x.rst = r; x.haz = h; x.br = b; x.tgt = t; x.gnt = g; x.rv = v;
      x.rd = d; x.e_req = eq; x.e_addr = ea; x.e_v = ev;
      x.e_ins = ei; x.e_pco = ep;
      return x;
   endfunction

   task automatic check(string name, int idx,
                        logic [127:0] act, logic [127:0] exp);
      vectors++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s #%0d: got %h expected %h", name, idx, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct {
      logic [31:0] a;
      bit          live;
   } fl_t;
   typedef struct {
      logic [31:0] i;
      logic [31:0] p;
   } ent_t;

   fl_t         infl[$];
   ent_t        pend[$];
   logic [31:0] m_pc;
   logic        m_v;
   logic [31:0] m_ins, m_pco;
   logic        exp_req;

   bit          mem_busy;
   int          mem_cnt;
   logic [31:0] mem_addr;

   function automatic logic [31:0] word(logic [31:0] a);
      return {a[15:0], ~a[15:0]} ^ 32'h0013_0000;
   endfunction

   task automatic model_reset();
      m_pc = RST_PC;
      infl.delete();
      pend.delete();
      m_v = 1'b0;
      m_ins = '0;
      m_pco = '0;
   endtask

   task automatic model_step();
      fl_t  f;
      ent_t e;
      bit   resp;
      bit   granted;
      resp = 0;
      f = '{a: '0, live: 0};
      if (rst) begin
         model_reset();
      end else begin
         granted = exp_req && gnt;
         if (rvalid && infl.size() > 0) begin
            f = infl.pop_front();
            resp = 1;
         end
         if (br) begin
            foreach (infl[j]) infl[j].live = 0;
            if (granted) infl.push_back('{a: m_pc, live: 0});
            m_pc = tgt;
            m_v = 1'b0;
            m_ins = '0;
            pend.delete();
         end else begin
            if (granted) begin
               infl.push_back('{a: m_pc, live: 1});
               m_pc = m_pc + 32'd4;
            end
            if (hazard) begin
               if (resp && f.live)
                  pend.push_back('{i: rdata, p: f.a + 32'd4});
            end else if (pend.size() > 0) begin
               e = pend.pop_front();
               m_ins = e.i;
               m_pco = e.p;
               m_v = 1'b1;
            end else if (resp && f.live) begin
               m_ins = rdata;
               m_pco = f.a + 32'd4;
               m_v = 1'b1;
            end else begin
               m_v = 1'b0;
            end
         end
      end
   endtask

   logic [31:0] g_addr;

   initial begin
      // rst haz br tgt gnt rv rdata | req addr | v ins pc_out
      tbl[0]  = mk(1,0,0,0,0,0,0, 0,32'h0, 0,0,0);
      tbl[1]  = mk(0,0,0,0,1,0,0, 1,32'h0, 0,0,0);
      tbl[2]  = mk(0,0,0,0,0,1,32'h20010005, 0,32'h4,
                   1,32'h20010005,32'h4);
      tbl[3]  = mk(0,0,0,0,1,0,0, 1,32'h4, 0,32'h20010005,32'h4);
      tbl[4]  = mk(0,0,0,0,0,1,32'h20020007, 0,32'h8,
                   1,32'h20020007,32'h8);
      tbl[5]  = mk(0,0,0,0,1,0,0, 1,32'h8, 0,32'h20020007,32'h8);
      tbl[6]  = mk(0,1,0,0,0,1,32'h20030009, 0,32'hC,
                   0,32'h20020007,32'h8);
      tbl[7]  = mk(0,1,0,0,0,0,0, 0,32'hC, 0,32'h20020007,32'h8);
      tbl[8]  = mk(0,1,0,0,0,0,0, 0,32'hC, 0,32'h20020007,32'h8);
      tbl[9]  = mk(0,0,0,0,0,0,0, 0,32'hC, 1,32'h20030009,32'hC);
      tbl[10] = mk(0,0,0,0,1,0,0, 1,32'hC, 0,32'h20030009,32'hC);
      tbl[11] = mk(0,0,0,0,0,1,32'h2004000B, 0,32'h10,
                   1,32'h2004000B,32'h10);
      tbl[12] = mk(0,0,0,0,1,0,0, 1,32'h10, 0,32'h2004000B,32'h10);
      tbl[13] = mk(0,0,1,32'h40,0,0,0, 0,32'h14, 0,0,32'h10);
      tbl[14] = mk(0,0,0,0,0,1,32'hDEAD0010, 0,32'h40, 0,0,32'h10);
      tbl[15] = mk(0,0,0,0,1,0,0, 1,32'h40, 0,0,32'h10);
      tbl[16] = mk(0,0,0,0,0,1,32'h20050001, 0,32'h44,
                   1,32'h20050001,32'h44);
      tbl[17] = mk(0,0,1,32'h14,0,0,0, 1,32'h44, 0,0,32'h44);
      tbl[18] = mk(0,0,1,32'h80,1,0,0, 1,32'h14, 0,0,32'h44);
      tbl[19] = mk(0,0,0,0,0,0,0, 0,32'h80, 0,0,32'h44);
      tbl[20] = mk(0,0,0,0,0,1,32'hBAD00014, 0,32'h80, 0,0,32'h44);
      tbl[21] = mk(0,0,0,0,1,0,0, 1,32'h80, 0,0,32'h44);
      tbl[22] = mk(0,0,0,0,0,1,32'h20060003, 0,32'h84,
                   1,32'h20060003,32'h84);
      tbl[23] = mk(0,0,0,0,1,0,0, 1,32'h84, 0,32'h20060003,32'h84);
      tbl[24] = mk(0,1,0,0,0,1,32'h20070005, 0,32'h88,
                   0,32'h20060003,32'h84);
      tbl[25] = mk(0,1,1,32'h100,0,0,0, 0,32'h88, 0,0,32'h84);
      tbl[26] = mk(0,0,0,0,0,0,0, 1,32'h100, 0,0,32'h84);
      tbl[27] = mk(0,0,0,0,1,0,0, 1,32'h100, 0,0,32'h84);
      tbl[28] = mk(1,0,0,0,0,0,0, 0,32'h0, 0,0,0);
      tbl[29] = mk(0,0,0,0,0,1,32'hBADBAD00, 1,32'h0, 0,0,0);
      tbl[30] = mk(0,0,0,0,1,0,0, 1,32'h0, 0,0,0);
      tbl[31] = mk(0,0,0,0,0,1,32'h11111111, 0,32'h4,
                   1,32'h11111111,32'h4);

      for (int i = 0; i < 32; i++) begin
         @(negedge clk);
         rst    = tbl[i].rst;
         hazard = tbl[i].haz;
         br     = tbl[i].br;
         tgt    = tbl[i].tgt;
         gnt    = tbl[i].gnt;
         rvalid = tbl[i].rv;
         rdata  = tbl[i].rd;
         #1;
         check("tbl_req_addr", i, {req, addr},
               {tbl[i].e_req, tbl[i].e_addr});
         @(posedge clk);
         #1;
         check("tbl_ifid", i, {vout, ins, pco},
               {tbl[i].e_v, tbl[i].e_ins, tbl[i].e_pco});
      end

      // Random phase starts from a clean reset.
      @(negedge clk);
      rst = 1'b1; hazard = 1'b0; br = 1'b0; gnt = 1'b0;
      rvalid = 1'b0; rdata = '0; tgt = '0;
      @(posedge clk);
      model_reset();
      mem_busy = 0;
      mem_cnt = 0;
      mem_addr = '0;
      exp_req = 1'b0;

      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         check("rnd_ifid", c, {vout, ins, pco}, {m_v, m_ins, m_pco});
         rvalid = 1'b0;
         rdata = $urandom;
         if (mem_busy) begin
            mem_cnt--;
            if (mem_cnt == 0) begin
               rvalid = 1'b1;
               rdata = word(mem_addr);
               mem_busy = 0;
            end
         end
         rst    = ($urandom_range(0, 59) == 0);
         hazard = ($urandom_range(0, 3) == 0);
         br     = ($urandom_range(0, 7) == 0);
         if ($urandom_range(0, 9) == 0)
            tgt = 32'hFFFF_FFF8;
         else
            tgt = 32'($urandom_range(0, 255)) << 2;
         gnt = 1'b0;
         #1;
         exp_req = !rst && infl.size() == 0 && pend.size() == 0
                   && !hazard;
         check("rnd_req_addr", c, {req, addr},
               {exp_req, rst ? RST_PC : m_pc});
         gnt = req && !mem_busy && ($urandom_range(0, 2) != 0);
         g_addr = m_pc;
         @(posedge clk);
         model_step();
         if (gnt) begin
            mem_busy = 1;
            mem_cnt = $urandom_range(1, 3);
            mem_addr = g_addr;
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, errors);
      $finish;
   end

endmodule
